ldl_rr_grant_mux: RTL
=====================

Name: ldl_rr_grant_mux

Overview:
Downstream consumer of the LDL round-robin arbiter (LDL_rr_v1). It takes the arbiter's valid/hot/bin grant, selects the granted requester's data word, and returns a one-cycle pop pulse to that requester. It presents the result on a registered valid/ready output through a 2-entry skid buffer, which gives full throughput and order preservation.

Parameters:
BIN_WIDTH, 3, width of the grant index.
REQ_WIDTH, 1 << BIN_WIDTH, number of requesters; must equal the arbiter's REQ_WIDTH.
DATA_WIDTH, 8, width of each requester's data word.

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  REQ_WIDTH*DATA_WIDTH  concatenated requester data; word i is bits [i*DATA_WIDTH +: DATA_WIDTH].
arb_valid  input  1  arbiter grant valid.
arb_hot  input  REQ_WIDTH  arbiter one-hot grant.
arb_bin  input  BIN_WIDTH  arbiter binary grant index.
arb_ready  output  1  drives the arbiter's ready input.
ack  output  REQ_WIDTH  one-hot pop to the granted requester; combinational.
out_valid  output  1  output word valid.
out_data  output  DATA_WIDTH  selected data word.
out_bin  output  BIN_WIDTH  index of the source requester.
out_ready  input  1  sink ready.
err  output  1  sticky grant-consistency error flag.

Behaviour:
- Signal definitions:
  - accept = arb_valid & arb_ready.
  - pop = out_valid & out_ready.
  - Data is selected by arb_bin: in_data word arb_bin; arb_hot is not used for muxing.
- ack = accept ? arb_hot : 0.
  - It is asserted in the same cycle as accept.
  - The requester deasserts or advances its req/data on the next edge.
- Storage: main register (M) and skid register (S). Each holds {data, bin}.
- State machine, with state register cnt in {EMPTY, ONE, TWO}:
  - EMPTY:
    - accept -> ONE, M <= new.
  - ONE:
    - accept & pop -> ONE, M <= new.
    - accept & !pop -> TWO, S <= new.
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - TWO:
    - pop -> ONE, M <= S.
    - no accept is possible in TWO.
- Output and ready derivation:
  - out_valid = (cnt != EMPTY).
  - {out_data, out_bin} = M. These are registered outputs, with no combinational path from in_data.
  - arb_ready = !rst & (cnt != TWO). It depends only on flops and rst, never on out_ready.
- Latency and throughput:
  - Accept to out_valid takes 1 cycle.
  - With out_ready held high, one word per cycle is sustained and cnt never leaves ONE while grants continue.
- Ordering: words leave in acceptance order. S is never overtaken.
- Backpressure:
  - When out_ready is low, at most 2 words buffer.
  - arb_ready then drops in the cycle after the second accept.
  - The arbiter must hold its grant while arb_ready is low (arbiter contract).
- err:
  - Set on any cycle where arb_valid=1 and arb_hot != (1 << arb_bin).
  - Sticky until rst.
  - The mismatching grant is still accepted per arb_bin.
- Reset (synchronous):
  - cnt=EMPTY, M=S=0, out_valid=0, out_data=0, out_bin=0, err=0.
  - arb_ready=0 and ack=0 while rst=1.
  - Reset mid-operation discards buffered words without a pop.
  - The first accept is possible on the first cycle after rst falls.
- Simultaneous accept and pop in ONE: the new word replaces M on the same edge, with no bubble.
- arb_valid=0: ack=0 and the state is unchanged except by pop.

Test Plan:
1. Single stream: requester 0 only, in_data word0=8'h11, out_ready=1 → ack=8'b00000001 in each accept cycle; out_valid a cycle later with out_data=8'h11, out_bin=0; one word per cycle.
2. Rotation: req=8'ha5 at the arbiter, word i = 8'h10+i, out_ready=1 → out_bin sequence 0,2,5,7,0,… with out_data 8'h10,12,15,17; ack one-hot matches each grant.
3. Backpressure: word stream with out_ready=0 for 4 cycles → exactly 2 accepts, then arb_ready=0. On out_ready=1, the words are emitted in order with no loss or duplication, and arb_ready=1 one cycle after the first pop.
4. Alternating out_ready (1,0,1,0…) for 20 cycles → the scoreboard sees the same ordered sequence as the accepts; cnt never exceeds TWO; no accept while arb_ready=0.
5. Error injection: arb_valid=1, arb_bin=3, arb_hot=8'b00000010 → err=1 the next cycle and held; output word = in_data word 3; err clears only on rst.
6. Mid-run reset: rst=1 with cnt=TWO → next cycle out_valid=0, out_data=0, arb_ready=0, ack=0; after rst=0, the first new grant appears on the output 1 cycle after accept.

Source files
------------

// File: rtl/ldl_rr_grant_mux.sv
// Grant consumer for the LDL round-robin arbiter: muxes the granted word, pops the
// requester, and presents the result through a 2-entry skid buffer.
module ldl_rr_grant_mux #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                            arb_valid,
  input  logic [REQ_WIDTH-1:0]            arb_hot,
  input  logic [BIN_WIDTH-1:0]            arb_bin,
  output logic                            arb_ready,
  output logic [REQ_WIDTH-1:0]            ack,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [BIN_WIDTH-1:0]            out_bin,
  input  logic                            out_ready,
  output logic                            err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BIN_WIDTH-1:0]  bin;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} cnt_t;

  cnt_t   cnt, cnt_nxt;
  entry_t m_q, s_q, m_nxt, s_nxt, new_e;
  logic   accept, pop;
  logic   [REQ_WIDTH-1:0][DATA_WIDTH-1:0] words;
  logic   [REQ_WIDTH-1:0] exp_hot;

  assign words     = in_data;
  assign arb_ready = !rst && (cnt != TWO);
  assign accept    = arb_valid && arb_ready;
  assign pop       = out_valid && out_ready;
  assign ack       = accept ? arb_hot : '0;
  assign exp_hot   = {{(REQ_WIDTH-1){1'b0}}, 1'b1} << arb_bin;

  // Mux by the binary index only; the one-hot form is just cross-checked for err.
  always_comb begin
    new_e      = '0;
    new_e.data = words[arb_bin];
    new_e.bin  = arb_bin;
  end

  always_comb begin
    cnt_nxt = cnt;
    m_nxt   = m_q;
    s_nxt   = s_q;
    unique case (cnt)
      EMPTY: if (accept) begin
        cnt_nxt = ONE;
        m_nxt   = new_e;
      end
      ONE: begin
        if (accept && pop) begin
          m_nxt = new_e;
        end else if (accept) begin
          cnt_nxt = TWO;
          s_nxt   = new_e;
        end else if (pop) begin
          cnt_nxt = EMPTY;
        end
      end
      TWO: if (pop) begin
        // arb_ready is low here, so the skid entry simply moves up.
        cnt_nxt = ONE;
        m_nxt   = s_q;
      end
      default: cnt_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= EMPTY;
      m_q <= '0;
      s_q <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      m_q <= m_nxt;
      s_q <= s_nxt;
      if (arb_valid && (arb_hot != exp_hot)) err <= 1'b1;
    end
  end

  assign out_valid = (cnt != EMPTY);
  assign out_data  = m_q.data;
  assign out_bin   = m_q.bin;

endmodule
